// File: rtl/audio_frame_mixer.sv
// Purpose: mixes NUM_SRC signed audio sources once per I2S frame with a shared MAC and saturation, then writes the master ring buffer.
// Latency: wr_en rises NUM_SRC+3 mclk cycles after the synced lrclk falling-edge tick; a tick lands 2 cycles after lrclk falls.
// Backpressure: none; a frame tick arriving while busy is dropped and flagged on the sticky overrun output.
module audio_frame_mixer #(
  parameter int NUM_SRC     = 3,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 256,
  parameter int ADDR_BITS   = 8,
  parameter int LAG         = 1
) (
  input  logic                           mclk,
  input  logic                           rstn,
  input  logic                           lrclk,
  input  logic [NUM_SRC*SAMPLE_BITS-1:0] src_sample,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*VOLUME_BITS-1:0] src_vol,
  input  logic [ADDR_BITS-1:0]           play_index,
  input  logic                           clip_clr,
  output logic                           wr_en,
  output logic [ADDR_BITS-1:0]           wr_addr,
  output logic [SAMPLE_BITS-1:0]         wr_data,
  output logic                           busy,
  output logic                           clip,
  output logic                           overrun
);

  // Accumulator is wide enough to hold NUM_SRC full-scale products without overflow.
  localparam int ACC_BITS  = SAMPLE_BITS + VOLUME_BITS + 1 + $clog2(NUM_SRC);
  localparam int PROD_BITS = SAMPLE_BITS + VOLUME_BITS + 1;
  localparam int IDX_BITS  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LAG_MOD   = LAG % BUF_LEN;
  localparam int SHIFT     = VOLUME_BITS - 1;

  localparam logic signed [ACC_BITS-1:0] Y_MAX = ACC_BITS'((1 << (SAMPLE_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] Y_MIN = -ACC_BITS'(1 << (SAMPLE_BITS - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_MAC,
    S_SAT,
    S_WRITE
  } state_t;

  state_t state_q, state_nxt;

  logic lrclk_s1, lrclk_cur, lrclk_prev;
  logic tick;

  logic [NUM_SRC*SAMPLE_BITS-1:0] smp_q;
  logic [NUM_SRC-1:0]             vld_q;
  logic [NUM_SRC*VOLUME_BITS-1:0] vol_q;
  logic [ADDR_BITS-1:0]           pi_q;
  logic [IDX_BITS-1:0]            idx_q;
  logic signed [ACC_BITS-1:0]     acc_q;

  logic signed [SAMPLE_BITS-1:0]  cur_smp;
  logic [VOLUME_BITS-1:0]         cur_vol;
  logic                           cur_vld;
  logic signed [VOLUME_BITS:0]    cur_gain;
  logic signed [PROD_BITS-1:0]    prod;
  logic signed [ACC_BITS-1:0]     term;
  logic signed [ACC_BITS-1:0]     y_full;
  logic [SAMPLE_BITS-1:0]         y_sat;
  logic                           y_clamped;
  logic                           mac_last;
  logic                           clip_set;
  logic                           overrun_set;

  // Two-flop synchroniser for the async lrclk, plus one more flop to detect the falling edge.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      lrclk_s1   <= 1'b0;
      lrclk_cur  <= 1'b0;
      lrclk_prev <= 1'b0;
    end else begin
      lrclk_s1   <= lrclk;
      lrclk_cur  <= lrclk_s1;
      lrclk_prev <= lrclk_cur;
    end
  end

  assign tick     = lrclk_prev & ~lrclk_cur;
  assign mac_last = (idx_q == IDX_BITS'(NUM_SRC - 1));

  // State register.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    state_nxt = state_q;
    wr_en     = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (tick) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_MAC;
      S_MAC:     if (mac_last) state_nxt = S_SAT;
      S_SAT:     state_nxt = S_WRITE;
      S_WRITE: begin
        wr_en     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Select the operands of the source currently being accumulated.
  always_comb begin
    cur_smp = '0;
    cur_vol = '0;
    cur_vld = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (idx_q == IDX_BITS'(i)) begin
        cur_smp = smp_q[i*SAMPLE_BITS +: SAMPLE_BITS];
        cur_vol = vol_q[i*VOLUME_BITS +: VOLUME_BITS];
        cur_vld = vld_q[i];
      end
    end
  end

  // Gain is unsigned, so zero-extend it before the signed multiply.
  assign cur_gain = $signed({1'b0, cur_vol});
  assign prod     = cur_smp * cur_gain;
  assign term     = cur_vld ? ACC_BITS'(prod) : '0;

  // Scale back to sample range (arithmetic shift floors toward -inf) and clamp.
  always_comb begin
    y_full    = acc_q >>> SHIFT;
    y_sat     = y_full[SAMPLE_BITS-1:0];
    y_clamped = 1'b0;
    if (y_full > Y_MAX) begin
      y_sat     = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
      y_clamped = 1'b1;
    end else if (y_full < Y_MIN) begin
      y_sat     = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
      y_clamped = 1'b1;
    end
  end

  assign clip_set    = (state_q == S_SAT) && y_clamped;
  assign overrun_set = tick && (state_q != S_IDLE);

  // Frame datapath: snapshot inputs, run the MAC, and update the held write outputs.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      smp_q   <= '0;
      vld_q   <= '0;
      vol_q   <= '0;
      pi_q    <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      wr_data <= '0;
      wr_addr <= '0;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          smp_q <= src_sample;
          vld_q <= src_valid;
          vol_q <= src_vol;
          pi_q  <= play_index;
          idx_q <= '0;
          acc_q <= '0;
        end
        S_MAC: begin
          acc_q <= acc_q + term;
          idx_q <= idx_q + 1'b1;
        end
        S_SAT: begin
          wr_data <= y_sat;
          wr_addr <= pi_q - ADDR_BITS'(LAG_MOD);
        end
        default: ;
      endcase
    end
  end

  // Sticky status flags; a set in the same cycle as clip_clr takes priority.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      clip    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clip_set)      clip <= 1'b1;
      else if (clip_clr) clip <= 1'b0;
      if (overrun_set)   overrun <= 1'b1;
      else if (clip_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_frame_mixer.sv
module tb_audio_frame_mixer;

  logic        mclk;
  logic        rstn;
  logic        lrclk;
  logic [47:0] src_sample;
  logic [2:0]  src_valid;
  logic [23:0] src_vol;
  logic [7:0]  play_index;
  logic        clip_clr;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        clip;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  bit clip_exp = 0;

  audio_frame_mixer dut (
    .mclk       (mclk),
    .rstn       (rstn),
    .lrclk      (lrclk),
    .src_sample (src_sample),
    .src_valid  (src_valid),
    .src_vol    (src_vol),
    .play_index (play_index),
    .clip_clr   (clip_clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .clip       (clip),
    .overrun    (overrun)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of gained samples, floor-divide by 128, clamp to int16.
  function automatic logic [15:0] model_mix(input logic [47:0] s, input logic [2:0] v,
                                            input logic [23:0] g, output bit sat);
    longint sum;
    longint y;
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) sum += longint'($signed(s[i*16 +: 16])) * longint'(g[i*8 +: 8]);
    end
    y   = sum >>> 7;
    sat = 1'b0;
    if (y > 32767) begin
      y = 32767;
      sat = 1'b1;
    end else if (y < -32768) begin
      y = -32768;
      sat = 1'b1;
    end
    return 16'(y);
  endfunction

  task automatic pulse_clip_clr();
    @(negedge mclk);
    clip_clr = 1'b1;
    @(negedge mclk);
    clip_clr = 1'b0;
  endtask

  task automatic lrclk_high();
    lrclk = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  // One frame: drive inputs, drop lrclk, expect a single wr_en 8 negedges later.
  task automatic run_frame(input string tag, input logic [47:0] s, input logic [2:0] v,
                           input logic [23:0] g, input logic [7:0] pi,
                           input logic [15:0] exp_data, input logic [7:0] exp_addr,
                           input bit scramble);
    int n_wr;
    int first_n;
    logic [15:0] got_data;
    logic [7:0]  got_addr;
    src_sample = s;
    src_valid  = v;
    src_vol    = g;
    play_index = pi;
    lrclk_high();
    lrclk   = 1'b0;
    n_wr    = 0;
    first_n = -1;
    got_data = 'x;
    got_addr = 'x;
    for (int n = 1; n <= 14; n++) begin
      @(negedge mclk);
      if (wr_en === 1'b1) begin
        n_wr++;
        if (first_n < 0) begin
          first_n  = n;
          got_data = wr_data;
          got_addr = wr_addr;
        end
      end
      if (n == 4 && scramble) begin
        src_sample = {$urandom, $urandom};
        src_valid  = 3'($urandom);
        src_vol    = 24'($urandom);
        play_index = 8'($urandom);
      end
    end
    check({tag, "_wr_count"}, n_wr, 1);
    check({tag, "_latency"}, first_n, 8);
    check({tag, "_data"}, got_data, exp_data);
    check({tag, "_addr"}, got_addr, exp_addr);
    check({tag, "_data_hold"}, wr_data, exp_data);
    check({tag, "_clip"}, clip, clip_exp);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    logic [47:0] s;
    logic [2:0]  v;
    logic [23:0] g;
    logic [7:0]  pi;
    logic [15:0] ed;
    bit          sat;
    int          n_wr;

    rstn       = 1'b0;
    lrclk      = 1'b0;
    src_sample = '0;
    src_valid  = '0;
    src_vol    = '0;
    play_index = '0;
    clip_clr   = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_clip", clip, 0);
    check("rst_overrun", overrun, 0);
    rstn = 1'b1;
    repeat (2) @(negedge mclk);

    // Unity gain sum: 1000 - 200 + 50.
    run_frame("unity", {16'h0032, 16'hFF38, 16'h03E8}, 3'b111, {8'd128, 8'd128, 8'd128},
              8'd5, 16'd850, 8'd4, 1'b1);
    // Half gain on src0, other sources invalid; play_index 0 wraps to 255.
    run_frame("gain64", {16'h7000, 16'h9000, 16'h03E8}, 3'b001, {8'd200, 8'd200, 8'd64},
              8'd0, 16'd500, 8'd255, 1'b1);
    // 1000*255/128 = 1992.19 truncates to 1992.
    run_frame("gain255", {16'h1234, 16'h4321, 16'h03E8}, 3'b001, {8'd9, 8'd9, 8'd255},
              8'd17, 16'd1992, 8'd16, 1'b0);

    // Positive and negative saturation with clip handling.
    clip_exp = 1'b1;
    run_frame("sat_pos", {16'h7530, 16'h7530, 16'h7530}, 3'b111, {8'd128, 8'd128, 8'd128},
              8'd100, 16'h7FFF, 8'd99, 1'b1);
    pulse_clip_clr();
    clip_exp = 1'b0;
    check("clip_cleared", clip, 0);
    clip_exp = 1'b1;
    run_frame("sat_neg", {16'h8AD0, 16'h8AD0, 16'h8AD0}, 3'b111, {8'd128, 8'd128, 8'd128},
              8'd1, 16'h8000, 8'd0, 1'b1);
    pulse_clip_clr();
    clip_exp = 1'b0;
    check("clip_cleared2", clip, 0);

    // Overrun: a second lrclk fall 3 cycles after the first.
    src_sample = {16'd0, 16'd0, 16'd300};
    src_valid  = 3'b001;
    src_vol    = {8'd0, 8'd0, 8'd128};
    play_index = 8'd50;
    lrclk_high();
    lrclk = 1'b0;
    n_wr  = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge mclk);
      if (n == 1) lrclk = 1'b1;
      if (n == 3) lrclk = 1'b0;
      if (wr_en === 1'b1) begin
        n_wr++;
        check("ovr_wr_time", n, 8);
        check("ovr_wr_data", wr_data, 16'd300);
        check("ovr_wr_addr", wr_addr, 8'd49);
      end
      if (n == 9) check("ovr_busy_low", busy, 0);
    end
    check("ovr_wr_count", n_wr, 1);
    check("ovr_flag", overrun, 1);
    pulse_clip_clr();
    check("ovr_cleared", overrun, 0);

    // Reset during MAC aborts the frame.
    src_sample = {16'd10, 16'd20, 16'd30};
    src_valid  = 3'b111;
    src_vol    = {8'd128, 8'd128, 8'd128};
    play_index = 8'd9;
    lrclk_high();
    lrclk = 1'b0;
    n_wr  = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge mclk);
      if (wr_en === 1'b1) n_wr++;
      if (n == 5) begin
        rstn = 1'b0;
        #1;
        check("mrst_wr_en", wr_en, 0);
        check("mrst_wr_data", wr_data, 0);
        check("mrst_wr_addr", wr_addr, 0);
        check("mrst_busy", busy, 0);
        check("mrst_clip", clip, 0);
        check("mrst_overrun", overrun, 0);
      end
    end
    check("mrst_no_write", n_wr, 0);
    rstn = 1'b1;
    clip_exp = 1'b0;
    @(negedge mclk);
    run_frame("post_rst", {16'd10, 16'd20, 16'd30}, 3'b111, {8'd128, 8'd128, 8'd128},
              8'd9, 16'd60, 8'd8, 1'b1);

    // Randomized frames against the arithmetic reference.
    for (int k = 0; k < 30; k++) begin
      s  = {$urandom, $urandom};
      v  = 3'($urandom);
      g  = 24'($urandom);
      pi = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        s = {16'h7FFF ^ 16'($urandom_range(0, 255)), 16'h7F00, 16'h7FF0};
        v = 3'b111;
      end
      ed = model_mix(s, v, g, sat);
      if (sat) clip_exp = 1'b1;
      run_frame($sformatf("rand%0d", k), s, v, g, pi, ed, pi - 8'd1, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        pulse_clip_clr();
        clip_exp = 1'b0;
        check($sformatf("rand%0d_clr", k), clip, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
